pe_scalar_pipe: RTL and testbench

- Registered, parametrised scalar processing element for the CGRA tile. It is the pipelined successor of the combinational scalar PE.
- Executes one scalar op per accepted beat: LUI, ADDI, ADD, SUB, BNE and BEQ.
- Adds one-cycle result forwarding into either operand, a valid/ready output handshake, signed-overflow detection and a saturating taken-branch counter.
- Sits between the tile register-file read port and the writeback/branch unit.

---
 rtl/pe_scalar_pipe_if.sv | 43 ++++
 rtl/pe_scalar_pipe.sv | 141 ++++++++++++++
 tb/tb_pe_scalar_pipe.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pe_scalar_pipe_if.sv
// Operand/result bundle for pe_scalar_pipe: input beat with valid/ready, result beat with valid/ready.
// Latency: none, wires only.
// Backpressure: in_ready follows out_ready whenever a result is held in the PE.
//
// Signals:
//   in_valid/in_ready      operand beat handshake (master -> PE)
//   op_scalar              000 LUI, 001 ADDI, 010 BNE, 011 ADD, 100 SUB, 101 BEQ, 11x NOP
//   inp1/inp2/R_immediate  operand A, operand B, pre-extended immediate
//   fwd_sel                bit0 forwards last result into A, bit1 into B
//   out_valid/out_ready    result beat handshake (PE -> master)
//   out1/flag_br/flag_ovf  result, branch condition, signed overflow
//   br_cnt/br_cnt_clr      saturating taken-branch count and its synchronous clear
interface pe_scalar_pipe_if #(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op_scalar;
    logic [DWIDTH-1:0]    inp1;
    logic [DWIDTH-1:0]    inp2;
    logic [DWIDTH-1:0]    R_immediate;
    logic [1:0]           fwd_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [DWIDTH-1:0]    out1;
    logic                 flag_br;
    logic                 flag_ovf;
    logic [CNT_WIDTH-1:0] br_cnt;
    logic                 br_cnt_clr;

    // Upstream/downstream side: drives operands and out_ready, observes results.
    modport master (
        output in_valid, op_scalar, inp1, inp2, R_immediate, fwd_sel, out_ready, br_cnt_clr,
        input  in_ready, out_valid, out1, flag_br, flag_ovf, br_cnt
    );

    // Processing-element side.
    modport slave (
        input  in_valid, op_scalar, inp1, inp2, R_immediate, fwd_sel, out_ready, br_cnt_clr,
        output in_ready, out_valid, out1, flag_br, flag_ovf, br_cnt
    );
endinterface

// File: rtl/pe_scalar_pipe.sv
// Registered scalar PE: LUI/ADDI/ADD/SUB/BNE/BEQ with result forwarding, overflow flag, branch counter.
// Latency: result registered one cycle after accept, one beat per cycle while out_ready is high.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds out1/flags and blocks input.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   io   pe_scalar_pipe_if slave modport (operand beat in, result beat out, branch counter)
module pe_scalar_pipe #(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    pe_scalar_pipe_if.slave  io
);

    typedef enum logic [2:0] {
        OP_LUI  = 3'b000,
        OP_ADDI = 3'b001,
        OP_BNE  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_BEQ  = 3'b101
    } op_e;

    localparam int MSB = DWIDTH - 1;

    logic [DWIDTH-1:0]    out1_q;
    logic                 out_valid_q;
    logic                 flag_br_q;
    logic                 flag_ovf_q;
    logic [CNT_WIDTH-1:0] br_cnt_q;
    logic [DWIDTH-1:0]    last_result_q;

    logic [DWIDTH-1:0]    a_eff;
    logic [DWIDTH-1:0]    b_eff;
    logic [DWIDTH-1:0]    sum_imm;
    logic [DWIDTH-1:0]    sum_ab;
    logic [DWIDTH-1:0]    diff_ab;
    logic                 ovf_imm;
    logic                 ovf_add;
    logic                 ovf_sub;

    logic [DWIDTH-1:0]    out1_d;
    logic                 flag_br_d;
    logic                 flag_ovf_d;

    logic                 accept;
    logic                 cnt_sat;

    // A slot frees up either when empty or when its beat leaves this cycle.
    assign io.in_ready = !out_valid_q || io.out_ready;
    assign accept      = io.in_valid && io.in_ready;

    // Forwarding uses the value captured at the previous accept, which is
    // independent of whether that beat has been consumed downstream.
    assign a_eff = io.fwd_sel[0] ? last_result_q : io.inp1;
    assign b_eff = io.fwd_sel[1] ? last_result_q : io.inp2;

    assign sum_imm = a_eff + io.R_immediate;
    assign sum_ab  = a_eff + b_eff;
    assign diff_ab = a_eff - b_eff;

    // Add overflows when both inputs share a sign the result does not.
    assign ovf_imm = (a_eff[MSB] == io.R_immediate[MSB]) && (sum_imm[MSB] != a_eff[MSB]);
    assign ovf_add = (a_eff[MSB] == b_eff[MSB])          && (sum_ab[MSB]  != a_eff[MSB]);
    // Subtract overflows when input signs differ and the result leaves A's sign.
    assign ovf_sub = (a_eff[MSB] != b_eff[MSB])          && (diff_ab[MSB] != a_eff[MSB]);

    always_comb begin
        out1_d     = '0;
        flag_br_d  = 1'b0;
        flag_ovf_d = 1'b0;
        case (op_e'(io.op_scalar))
            OP_LUI: begin
                out1_d = io.R_immediate;
            end
            OP_ADDI: begin
                out1_d     = sum_imm;
                flag_ovf_d = ovf_imm;
            end
            OP_ADD: begin
                out1_d     = sum_ab;
                flag_ovf_d = ovf_add;
            end
            OP_SUB: begin
                out1_d     = diff_ab;
                flag_ovf_d = ovf_sub;
            end
            OP_BNE: begin
                flag_br_d = (a_eff != b_eff);
            end
            OP_BEQ: begin
                flag_br_d = (a_eff == b_eff);
            end
            default: begin
                // NOP: zero result, no flags, beat still produced.
            end
        endcase
    end

    assign cnt_sat = &br_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q   <= 1'b0;
            out1_q        <= '0;
            flag_br_q     <= 1'b0;
            flag_ovf_q    <= 1'b0;
            last_result_q <= '0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out1_q        <= out1_d;
            flag_br_q     <= flag_br_d;
            flag_ovf_q    <= flag_ovf_d;
            last_result_q <= out1_d;
        end else if (io.out_ready) begin
            // Data registers keep their value; only the valid drops.
            out_valid_q   <= 1'b0;
        end
    end

    // Clear has priority over an increment landing in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q <= '0;
        end else if (io.br_cnt_clr) begin
            br_cnt_q <= '0;
        end else if (accept && flag_br_d && !cnt_sat) begin
            br_cnt_q <= br_cnt_q + 1'b1;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.out1      = out1_q;
    assign io.flag_br   = flag_br_q;
    assign io.flag_ovf  = flag_ovf_q;
    assign io.br_cnt    = br_cnt_q;

endmodule

// File: tb/tb_pe_scalar_pipe.sv
// Directed bench for pe_scalar_pipe with a result scoreboard.
// Latency: expects each accepted beat on the output one cycle later.
// Backpressure: exercises out_ready stalls and an asynchronous reset during a stall.
module tb_pe_scalar_pipe;

    localparam int DW = 32;

    localparam logic [2:0] LUI  = 3'b000;
    localparam logic [2:0] ADDI = 3'b001;
    localparam logic [2:0] BNE  = 3'b010;
    localparam logic [2:0] ADD  = 3'b011;
    localparam logic [2:0] SUB  = 3'b100;
    localparam logic [2:0] BEQ  = 3'b101;
    localparam logic [2:0] NOP  = 3'b110;

    typedef struct packed {
        logic [DW-1:0] out1;
        logic          br;
        logic          ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb[$];

    pe_scalar_pipe_if #(.DWIDTH(DW), .CNT_WIDTH(16)) io  ();
    pe_scalar_pipe_if #(.DWIDTH(DW), .CNT_WIDTH(2))  io2 ();

    pe_scalar_pipe #(.DWIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    pe_scalar_pipe #(.DWIDTH(DW), .CNT_WIDTH(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .io  (io2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one beat (call at posedge+1), waits for acceptance, returns at posedge+1 after it.
    task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] imm, input logic [1:0] fwd,
                        input logic [DW-1:0] e_out, input logic e_br, input logic e_ovf,
                        input bit push);
        bit ok;
        exp_t e;
        io.in_valid    = 1'b1;
        io.op_scalar   = op;
        io.inp1        = a;
        io.inp2        = b;
        io.R_immediate = imm;
        io.fwd_sel     = fwd;
        e.out1 = e_out;
        e.br   = e_br;
        e.ovf  = e_ovf;
        if (push) sb.push_back(e);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (io.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        check("latency_valid", {31'd0, io.out_valid}, 32'd1);
    endtask

    // Scoreboard: every completed output beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && io.out_valid === 1'b1 && io.out_ready === 1'b1) begin
            exp_t e;
            checks++;
            assert (sb.size() > 0)
            else begin
                errors++;
                $error("FAIL sb_unexpected_beat observed=%h expected=none", io.out1);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out1", io.out1, e.out1);
                check("flag_br", {31'd0, io.flag_br}, {31'd0, e.br});
                check("flag_ovf", {31'd0, io.flag_ovf}, {31'd0, e.ovf});
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        io.in_valid = 1'b0;  io.op_scalar = NOP; io.inp1 = '0; io.inp2 = '0;
        io.R_immediate = '0; io.fwd_sel = 2'b00; io.out_ready = 1'b1; io.br_cnt_clr = 1'b0;
        io2.in_valid = 1'b0; io2.op_scalar = NOP; io2.inp1 = '0; io2.inp2 = '0;
        io2.R_immediate = '0; io2.fwd_sel = 2'b00; io2.out_ready = 1'b1; io2.br_cnt_clr = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("rst_out1", io.out1, 32'd0);
        check("rst_flag_br", {31'd0, io.flag_br}, 32'd0);
        check("rst_flag_ovf", {31'd0, io.flag_ovf}, 32'd0);
        check("rst_br_cnt", {16'd0, io.br_cnt}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, io.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic ops
        send(ADDI, 32'd5, 32'd0, 32'd3, 2'b00, 32'd8, 1'b0, 1'b0, 1'b1);
        send(LUI, 32'd77, 32'd0, 32'h0000_ABCD, 2'b00, 32'h0000_ABCD, 1'b0, 1'b0, 1'b1);
        send(NOP, 32'd5, 32'd6, 32'd7, 2'b00, 32'd0, 1'b0, 1'b0, 1'b1);
        send(ADDI, 32'hFFFF_FFFF, 32'd0, 32'd1, 2'b00, 32'd0, 1'b0, 1'b0, 1'b1);

        // Forwarding back-to-back
        send(ADD, 32'd7, 32'd9, 32'd0, 2'b00, 32'd16, 1'b0, 1'b0, 1'b1);
        send(ADD, 32'd100, 32'd4, 32'd0, 2'b01, 32'd20, 1'b0, 1'b0, 1'b1);
        send(SUB, 32'd50, 32'd100, 32'd0, 2'b10, 32'd30, 1'b0, 1'b0, 1'b1);
        send(ADD, 32'd1, 32'd2, 32'd0, 2'b11, 32'd60, 1'b0, 1'b0, 1'b1);

        // Overflow boundaries
        send(ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 2'b00, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        send(SUB, 32'h8000_0000, 32'd1, 32'd0, 2'b00, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        send(SUB, 32'd1, 32'd2, 32'd0, 2'b00, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

        // Branches and counter
        check("br_cnt_pre", {16'd0, io.br_cnt}, 32'd0);
        send(BNE, 32'd3, 32'd4, 32'd0, 2'b00, 32'd0, 1'b1, 1'b0, 1'b1);
        send(BEQ, 32'd2, 32'd2, 32'd0, 2'b00, 32'd0, 1'b1, 1'b0, 1'b1);
        send(BNE, 32'd6, 32'd6, 32'd0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b1);
        check("br_cnt_two", {16'd0, io.br_cnt}, 32'd2);
        io.br_cnt_clr = 1'b1;
        send(BEQ, 32'd5, 32'd5, 32'd0, 2'b00, 32'd0, 1'b1, 1'b0, 1'b1);
        io.br_cnt_clr = 1'b0;
        check("br_cnt_clr_wins", {16'd0, io.br_cnt}, 32'd0);

        // Output stall
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        send(ADD, 32'd10, 32'd20, 32'd0, 2'b00, 32'd30, 1'b0, 1'b0, 1'b1);
        io.in_valid  = 1'b1;
        io.op_scalar = ADD;
        io.inp1      = 32'd999;
        io.inp2      = 32'd1;
        io.fwd_sel   = 2'b01;
        sb.push_back('{out1: 32'd31, br: 1'b0, ovf: 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, io.in_ready}, 32'd0);
            check("stall_out1", io.out1, 32'd30);
            check("stall_out_valid", {31'd0, io.out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        io.out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {31'd0, io.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        check("release_out1", io.out1, 32'd31);
        @(posedge clk);
        #1;

        // Saturating counter on the narrow instance
        io2.in_valid  = 1'b1;
        io2.op_scalar = BNE;
        io2.inp1      = 32'd1;
        io2.inp2      = 32'd2;
        for (int i = 0; i < 5; i++) begin
            logic [DW-1:0] exp_cnt;
            exp_cnt = (i < 3) ? DW'(i + 1) : 32'd3;
            @(posedge clk);
            #1;
            check("sat_br_cnt", {30'd0, io2.br_cnt}, exp_cnt);
        end
        io2.in_valid  = 1'b0;
        io2.out_ready = 1'b0;

        // Asynchronous reset while both instances are stalled
        io.out_ready = 1'b0;
        send(ADD, 32'd1, 32'd1, 32'd0, 2'b00, 32'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("arst_out1", io.out1, 32'd0);
        check("arst_sat_valid", {31'd0, io2.out_valid}, 32'd0);
        check("arst_sat_br_cnt", {30'd0, io2.br_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        io.out_ready  = 1'b1;
        io2.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // last_result must have been cleared by reset
        send(ADD, 32'd50, 32'd60, 32'd0, 2'b11, 32'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
